slice_serial_adder: RTL

Sequential multi-word adder built around the team's 4-bit carry-skip slice. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It then adds them one 4-bit slice per clock, least-significant slice first, using carry-skip logic per slice, and presents the WIDTH-bit sum, carry-out and skip statistics through a second valid/ready handshake. It is the control stage wrapped around the 4-bit carry-skip adder, extending that adder to wide operands for downstream datapath consumers.

---
 rtl/slice_serial_adder_if.sv | 27 ++
 rtl/slice_serial_adder.sv | 133 +++++++++++++
 2 files changed

// File: rtl/slice_serial_adder_if.sv
// Operand and result handshake bundle for slice_serial_adder.
// The master side issues operands and takes results; the slave side is the adder.
interface slice_serial_adder_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH / 4 + 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [CNT_W-1:0] skip_cnt;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, skip_cnt
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, skip_cnt
  );
endinterface

// File: rtl/slice_serial_adder.sv
// Wide adder that runs one 4-bit carry-skip slice per clock, LSB slice first,
// and reports sum, carry-out and the number of slices whose carry was skipped.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding slice idx_q this cycle
// DONE  | result held, out_valid high until out_ready
module slice_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  slice_serial_adder_if.slave bus
);
  localparam int N     = WIDTH / 4;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = $clog2(N);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
    $error("slice_serial_adder: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   skip_q, skip_d;

  logic [IDX_W+1:0]   base;
  logic [3:0]         slice_a, slice_b, slice_p, slice_g, slice_s;
  logic [4:0]         ripple_c;
  logic               slice_skip;
  logic               slice_co;

  assign base = {idx_q, 2'b00};

  // One carry-skip slice: ripple chain plus a bypass mux when all bits propagate.
  always_comb begin
    slice_a     = a_q[base +: 4];
    slice_b     = b_q[base +: 4];
    slice_p     = slice_a ^ slice_b;
    slice_g     = slice_a & slice_b;
    ripple_c    = '0;
    ripple_c[0] = carry_q;
    for (int k = 0; k < 4; k++) begin
      ripple_c[k+1] = slice_g[k] | (slice_p[k] & ripple_c[k]);
    end
    slice_s    = slice_p ^ ripple_c[3:0];
    slice_skip = &slice_p;
    slice_co   = slice_skip ? carry_q : ripple_c[4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      skip_q  <= skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    skip_d  = skip_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          sum_d   = '0;
          skip_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: 4] = slice_s;
        carry_d          = slice_co;
        if (slice_skip) begin
          skip_d = skip_q + CNT_W'(1);
        end
        if (idx_q == IDX_W'(N - 1)) begin
          cout_d  = slice_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags come straight from the state flops.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.skip_cnt  = skip_q;
endmodule
